// File: rtl/gba_fb_pkg.sv
// gba_fb_pkg: shared constants and FSM state type for the GBA frame buffer writer.
package gba_fb_pkg;
    localparam int GBA_COLS = 240;
    localparam int GBA_ROWS = 160;
    localparam int GBA_PIXELS = 38400;
    localparam logic [16:0] FB_BUF1_BASE = 17'd38400;
    localparam int FB_ADDR_W = 17;
    localparam int PIX_W = 15;
    typedef enum logic [1:0] {WAIT_SOF, WRITE, WAIT_FLIP} fb_wr_state_t;
endpackage

// File: rtl/fb_pix_counter.sv
// fb_pix_counter: raster pixel index with clear, increment enable and a last-pixel flag.
// Ports: clock, reset (async, active-high), clr (restart at 0), inc (count one pixel;
// with clr the pixel counts as index 0), idx (current index), last (idx == PIXELS-1).
module fb_pix_counter #(
    parameter int PIXELS = 38400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] idx,
    output logic        last
);
    always_ff @(posedge clock or posedge reset)
        if (reset)
            idx <= '0;
        else if (clr || inc)
            idx <= (clr ? 16'd0 : idx) + {15'd0, inc};
    assign last = idx == 16'(PIXELS - 1);
endmodule

// File: rtl/gba_fb_writer.sv
// gba_fb_writer: writes the PPU pixel stream into the back half of a double buffer and flips between VGA frames.
// Ports: clock, reset (async, active-high); PPU side frame_start, pix_valid, pix_data;
// VGA side vga_frame_end, rd_base; memory side wr_en, wr_addr, wr_data;
// status frames_dropped (saturating), short_frame and overflow (sticky).
module gba_fb_writer
    import gba_fb_pkg::*;
#(
    parameter int          PIXELS    = GBA_PIXELS,
    parameter logic [16:0] BUF1_BASE = FB_BUF1_BASE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 vga_frame_end,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic [FB_ADDR_W-1:0] rd_base,
    output logic [7:0]           frames_dropped,
    output logic                 short_frame,
    output logic                 overflow
);
    fb_wr_state_t st;
    logic front, flip, new_front, wr, last;
    logic [15:0] idx, wr_idx;
    logic [16:0] back_base;

    // A flip is only legal once the frame is complete; a coincident frame_start
    // then writes into the freshly freed buffer, so addressing uses new_front.
    assign flip      = st == WAIT_FLIP && vga_frame_end;
    assign new_front = front ^ flip;
    assign wr        = pix_valid && (frame_start || st == WRITE);
    assign wr_idx    = frame_start ? 16'd0 : idx;
    assign back_base = new_front ? 17'd0 : BUF1_BASE;

    fb_pix_counter #(.PIXELS(PIXELS)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (frame_start),
        .inc   (wr),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st             <= WAIT_SOF;
            front          <= 1'b0;
            rd_base        <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            frames_dropped <= '0;
            short_frame    <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            front   <= new_front;
            rd_base <= new_front ? BUF1_BASE : 17'd0;
            wr_en   <= wr;
            if (wr) begin
                wr_addr <= back_base + {1'b0, wr_idx};
                wr_data <= pix_data;
            end
            if (frame_start && st == WRITE)
                short_frame <= 1'b1;
            if (st == WAIT_FLIP && pix_valid && !frame_start)
                overflow <= 1'b1;
            if (st == WAIT_FLIP && frame_start && !vga_frame_end && frames_dropped != 8'hFF)
                frames_dropped <= frames_dropped + 8'd1;
            if (frame_start)
                st <= WRITE;
            else if (st == WRITE && wr && last)
                st <= WAIT_FLIP;
            else if (flip)
                st <= WAIT_SOF;
        end
    end
endmodule

// File: tb/tb_gba_fb_writer.sv
// tb_gba_fb_writer: directed self-checking bench for gba_fb_writer (reduced frame size).
module tb_gba_fb_writer;
    localparam int P = 48;
    localparam logic [16:0] B1 = 17'd38400;

    logic clk = 1'b0, rst = 1'b1;
    logic fs = 1'b0, pv = 1'b0, vfe = 1'b0;
    logic [14:0] pd = '0;
    logic wr_en, short_frame, overflow;
    logic [16:0] wr_addr, rd_base;
    logic [14:0] wr_data;
    logic [7:0] frames_dropped;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    gba_fb_writer #(.PIXELS(P), .BUF1_BASE(B1)) dut (
        .clock          (clk),
        .reset          (rst),
        .frame_start    (fs),
        .pix_valid      (pv),
        .pix_data       (pd),
        .vga_frame_end  (vfe),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_base        (rd_base),
        .frames_dropped (frames_dropped),
        .short_frame    (short_frame),
        .overflow       (overflow)
    );

    typedef struct {
        logic        fs, pv, vfe;
        logic [14:0] d;
        logic        en;
        logic [16:0] addr;
        logic [14:0] wd;
        logic [16:0] rd;
        logic        sh;
    } vec_t;
    vec_t v[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_base"}, rd_base, 0);
        chk({tag, "_dropped"}, frames_dropped, 0);
        chk({tag, "_short"}, short_frame, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic send_frame(input logic [16:0] base, input bit vfe0, input bit per_px);
        int n;
        logic [14:0] exp_d;
        n = 0;
        for (int i = 0; i < P; i++) begin
            fs = (i == 0);
            vfe = vfe0 && (i == 0);
            pv = 1'b1;
            exp_d = 15'(i * 37 + int'(base));
            pd = exp_d;
            tick();
            fs = 1'b0;
            vfe = 1'b0;
            n += int'(wr_en);
            if (per_px) begin
                chk("px_en", wr_en, 1);
                chk("px_addr", wr_addr, base + 17'(i));
                chk("px_data", wr_data, exp_d);
            end
        end
        pv = 1'b0;
        tick();
        chk("frame_end_en", wr_en, 0);
        chk("frame_en_count", n, P);
    endtask

    initial begin
        v[0] = '{fs:0, pv:1, vfe:0, d:15'h0011, en:0, addr:17'd0,      wd:15'h0,    rd:17'd0, sh:0};
        v[1] = '{fs:1, pv:1, vfe:0, d:15'h1234, en:1, addr:B1,         wd:15'h1234, rd:17'd0, sh:0};
        v[2] = '{fs:0, pv:0, vfe:0, d:15'h7FFF, en:0, addr:17'd0,      wd:15'h0,    rd:17'd0, sh:0};
        v[3] = '{fs:0, pv:1, vfe:0, d:15'h0005, en:1, addr:B1 + 17'd1, wd:15'h0005, rd:17'd0, sh:0};
        v[4] = '{fs:0, pv:1, vfe:1, d:15'h7C1F, en:1, addr:B1 + 17'd2, wd:15'h7C1F, rd:17'd0, sh:0};
        v[5] = '{fs:1, pv:0, vfe:0, d:15'h0000, en:0, addr:17'd0,      wd:15'h0,    rd:17'd0, sh:1};
        v[6] = '{fs:0, pv:1, vfe:0, d:15'h0009, en:1, addr:B1,         wd:15'h0009, rd:17'd0, sh:1};

        repeat (3) tick();
        chk_reset_values("rst");
        rst = 1'b0;

        // WAIT_SOF ignores pixels, partial frame, ignored vga_frame_end, short restart
        for (int i = 0; i < 7; i++) begin
            fs = v[i].fs; pv = v[i].pv; vfe = v[i].vfe; pd = v[i].d;
            tick();
            chk($sformatf("vec%0d_en", i), wr_en, v[i].en);
            if (v[i].en) begin
                chk($sformatf("vec%0d_addr", i), wr_addr, v[i].addr);
                chk($sformatf("vec%0d_data", i), wr_data, v[i].wd);
            end
            chk($sformatf("vec%0d_rd", i), rd_base, v[i].rd);
            chk($sformatf("vec%0d_short", i), short_frame, v[i].sh);
        end
        fs = 0; pv = 0; vfe = 0;

        // first full frame into buffer 1, then flip
        send_frame(B1, 0, 1);
        chk("f1_rd_before_flip", rd_base, 0);
        vfe = 1; tick(); vfe = 0;
        chk("f1_rd_after_flip", rd_base, B1);

        // second frame into buffer 0, flip back
        send_frame(17'd0, 0, 1);
        chk("f2_rd_before_flip", rd_base, B1);
        vfe = 1; tick(); vfe = 0;
        chk("f2_rd_after_flip", rd_base, 0);

        // completed frame dropped by a new frame_start
        send_frame(B1, 0, 0);
        chk("drop0", frames_dropped, 0);
        send_frame(B1, 0, 1);
        chk("drop1", frames_dropped, 1);
        chk("drop1_rd", rd_base, 0);

        // pixels after completion: no writes, overflow
        chk("ovf_before", overflow, 0);
        pv = 1;
        for (int i = 0; i < 5; i++) begin
            pd = 15'(i);
            tick();
            chk("ovf_no_write", wr_en, 0);
        end
        pv = 0;
        chk("ovf_set", overflow, 1);

        // simultaneous frame_start + vga_frame_end: flip then write buffer 0, no drop
        send_frame(17'd0, 1, 1);
        chk("simul_rd", rd_base, B1);
        chk("simul_no_drop", frames_dropped, 1);

        // saturation of frames_dropped: 299 more drops (300 total)
        for (int k = 2; k <= 300; k++) begin
            send_frame(17'd0, 0, 0);
            if (k == 254) chk("drop254", frames_dropped, 254);
            if (k == 255) chk("drop255", frames_dropped, 255);
            if (k == 256) chk("drop256_sat", frames_dropped, 255);
        end
        chk("drop300_sat", frames_dropped, 255);
        chk("sat_rd", rd_base, B1);

        // reset in the middle of a frame
        fs = 1; pv = 1; pd = 15'h0ABC;
        tick();
        fs = 0;
        tick(); tick();
        chk("mid_en_before_rst", wr_en, 1);
        chk("mid_addr_before_rst", wr_addr, 17'd2);
        pv = 0;
        rst = 1'b1;
        #1;
        chk("async_en_drop", wr_en, 0);
        chk_reset_values("midrst");
        tick();
        rst = 1'b0;
        pv = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ignore", wr_en, 0);
        end
        pv = 0;
        send_frame(B1, 0, 1);
        vfe = 1; tick(); vfe = 0;
        chk("post_rst_flip", rd_base, B1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
